ecc_apb_ctrl: RTL and testbench

//  APB slave register file and operation sequencer feeding the ECC encoder stage directly.

---
 rtl/ecc_pkg.sv | 46 ++++
 rtl/ecc_apb_regs.sv | 81 ++++++++
 rtl/ecc_apb_ctrl.sv | 116 +++++++++++
 tb/tb_ecc_apb_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants for the ECC APB controller: register offsets, width codes,
// payload alignment and codeword masks, and the sequencer state type.
package ecc_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_DATA_IN  = 3'd1;
    localparam logic [2:0] REG_WIDTH    = 3'd2;
    localparam logic [2:0] REG_NOISE    = 3'd3;
    localparam logic [2:0] REG_DATA_OUT = 3'd4;

    localparam logic [1:0] W_SMALL  = 2'd0;
    localparam logic [1:0] W_MEDIUM = 2'd1;
    localparam logic [1:0] W_LARGE  = 2'd2;

    localparam logic [31:0] MASK_SMALL  = 32'h0000_00FF;
    localparam logic [31:0] MASK_MEDIUM = 32'h0000_FFFF;
    localparam logic [31:0] MASK_LARGE  = 32'hFFFF_FFFF;

    localparam logic [31:0] DMASK_SMALL  = 32'h0000_000F;
    localparam logic [31:0] DMASK_MEDIUM = 32'h0000_07FF;
    localparam logic [31:0] DMASK_LARGE  = 32'h03FF_FFFF;

    localparam int SHIFT_SMALL  = 28;
    localparam int SHIFT_MEDIUM = 21;
    localparam int SHIFT_LARGE  = 6;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    // Width codes 2 and 3 both select the large codeword.
    function automatic logic [31:0] cw_mask(input logic [1:0] w);
        case (w)
            W_SMALL:  return MASK_SMALL;
            W_MEDIUM: return MASK_MEDIUM;
            default:  return MASK_LARGE;
        endcase
    endfunction

    function automatic logic [31:0] left_align(input logic [1:0] w, input logic [31:0] d);
        case (w)
            W_SMALL:  return (d & DMASK_SMALL) << SHIFT_SMALL;
            W_MEDIUM: return (d & DMASK_MEDIUM) << SHIFT_MEDIUM;
            default:  return (d & DMASK_LARGE) << SHIFT_LARGE;
        endcase
    endfunction

endpackage

// File: rtl/ecc_apb_regs.sv
// APB decode and register storage for the ECC controller. Writes stall while the
// sequencer is busy. The NOISE register only exists when ECC_CTRL_NOISE_EN is defined.
module ecc_apb_regs
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           reg_addr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [AMBA_WORD-1:0] pwdata,
    output logic [AMBA_WORD-1:0] prdata,
    output logic                 pready,
    input  logic                 busy,
    input  logic [AMBA_WORD-1:0] data_out,
    output logic [AMBA_WORD-1:0] data_in,
    output logic [1:0]           width,
`ifdef ECC_CTRL_NOISE_EN
    output logic [AMBA_WORD-1:0] start_noise,
`endif
    output logic                 start
);

    logic [1:0]           ctrl_q;
    logic                 wr_en;
    logic [AMBA_WORD-1:0] rd_mux;
`ifdef ECC_CTRL_NOISE_EN
    logic [AMBA_WORD-1:0] noise_q;

    // Taken from the CTRL write data itself so the sequencer snapshots the new noise bit.
    assign start_noise = pwdata[1] ? noise_q : '0;
`endif

    assign pready = !(pwrite && busy);
    assign wr_en  = psel && penable && pwrite && pready;
    assign start  = wr_en && (reg_addr == REG_CTRL);

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_CTRL:     rd_mux = {{(AMBA_WORD-2){1'b0}}, ctrl_q};
            REG_DATA_IN:  rd_mux = data_in;
            REG_WIDTH:    rd_mux = {{(AMBA_WORD-2){1'b0}}, width};
`ifdef ECC_CTRL_NOISE_EN
            REG_NOISE:    rd_mux = noise_q;
`endif
            REG_DATA_OUT: rd_mux = data_out;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            data_in <= '0;
            width   <= '0;
            prdata  <= '0;
`ifdef ECC_CTRL_NOISE_EN
            noise_q <= '0;
`endif
        end else begin
            if (wr_en) begin
                case (reg_addr)
                    REG_CTRL:    ctrl_q  <= pwdata[1:0];
                    REG_DATA_IN: data_in <= pwdata;
                    REG_WIDTH:   width   <= pwdata[1:0];
`ifdef ECC_CTRL_NOISE_EN
                    REG_NOISE:   noise_q <= pwdata;
`endif
                    default:     ;
                endcase
            end
            if (psel && !penable && !pwrite)
                prdata <= rd_mux;
        end
    end

endmodule

// File: rtl/ecc_apb_ctrl.sv
// ECC APB controller top: register file plus the encoder operation sequencer.
// Optional build macro ECC_CTRL_NOISE_EN adds the NOISE register and result corruption.
//
//  state  | meaning
//  IDLE   | waiting for a CTRL write; mode outputs hold the last snapshot
//  LOAD   | mode outputs and enc_data presented; encoder samples at end of cycle
//  WAIT   | encoder output valid; capture masked codeword into DATA_OUT
//  DONE   | operation_done high for this single cycle
module ecc_apb_ctrl
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       Small,
    output logic                       Medium,
    output logic                       Large,
    output logic [AMBA_WORD-1:0]       enc_data,
    input  logic [AMBA_WORD-1:0]       Enc_Out,
    output logic                       operation_done
);

    state_t               state;
    logic                 start;
    logic                 busy;
    logic [1:0]           width;
    logic [AMBA_WORD-1:0] data_in;
    logic [AMBA_WORD-1:0] data_out;
    logic [AMBA_WORD-1:0] mask_q;
    logic                 unused_addr;
`ifdef ECC_CTRL_NOISE_EN
    logic [AMBA_WORD-1:0] start_noise;
    logic [AMBA_WORD-1:0] noise_q;
`endif

    assign busy        = (state != S_IDLE);
    assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

    ecc_apb_regs #(.AMBA_WORD(AMBA_WORD)) u_regs (
        .clk         (clk),
        .rst         (rst),
        .reg_addr    (PADDR[4:2]),
        .psel        (PSEL),
        .penable     (PENABLE),
        .pwrite      (PWRITE),
        .pwdata      (PWDATA),
        .prdata      (PRDATA),
        .pready      (PREADY),
        .busy        (busy),
        .data_out    (data_out),
        .data_in     (data_in),
        .width       (width),
`ifdef ECC_CTRL_NOISE_EN
        .start_noise (start_noise),
`endif
        .start       (start)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            Small          <= 1'b0;
            Medium         <= 1'b0;
            Large          <= 1'b0;
            enc_data       <= '0;
            mask_q         <= '0;
            data_out       <= '0;
            operation_done <= 1'b0;
`ifdef ECC_CTRL_NOISE_EN
            noise_q        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    operation_done <= 1'b0;
                    if (start) begin
                        Small    <= (width == W_SMALL);
                        Medium   <= (width == W_MEDIUM);
                        Large    <= (width >= W_LARGE);
                        enc_data <= left_align(width, data_in);
                        mask_q   <= cw_mask(width);
`ifdef ECC_CTRL_NOISE_EN
                        noise_q  <= start_noise;
`endif
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_WAIT;
                S_WAIT: begin
`ifdef ECC_CTRL_NOISE_EN
                    data_out <= (Enc_Out ^ noise_q) & mask_q;
`else
                    data_out <= Enc_Out & mask_q;
`endif
                    operation_done <= 1'b1;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    operation_done <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Directed bench for ecc_apb_ctrl with a registered encoder stub that knows the
// codewords of the tested payloads and drives junk above the codeword width.
module tb_ecc_apb_ctrl;

    localparam logic [19:0] A_CTRL     = 20'h00;
    localparam logic [19:0] A_DATA_IN  = 20'h04;
    localparam logic [19:0] A_WIDTH    = 20'h08;
    localparam logic [19:0] A_NOISE    = 20'h0C;
    localparam logic [19:0] A_DATA_OUT = 20'h10;
    localparam logic [19:0] A_UNMAPPED = 20'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] PADDR = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        Small, Medium, Large;
    logic [31:0] enc_data;
    logic [31:0] Enc_Out = '0;
    logic        operation_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    ecc_apb_ctrl #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .Small          (Small),
        .Medium         (Medium),
        .Large          (Large),
        .enc_data       (enc_data),
        .Enc_Out        (Enc_Out),
        .operation_done (operation_done)
    );

    function automatic logic [31:0] enc_model(input logic s, input logic m, input logic l,
                                              input logic [31:0] d);
        logic [31:0] cw;
        cw = 32'hDEAD_BEEF;
        if (s && !m && !l) begin
            if (d == 32'h1000_0000)      cw = 32'hA5A5_A51B;
            else if (d == 32'hF000_0000) cw = 32'hA5A5_A5FF;
        end else if (m && !s && !l) begin
            if (d == 32'h0000_0000)      cw = 32'hA5A5_0000;
        end else if (l && !s && !m) begin
            if (d == 32'hFFFF_FFC0)      cw = 32'hFFFF_FFDD;
        end
        return cw;
    endfunction

    always @(posedge clk) Enc_Out <= enc_model(Small, Medium, Large, enc_data);
    always @(posedge clk) if (operation_done) done_cnt <= done_cnt + 1;

    // Called #1 after a clock edge; returns #1 after the edge that committed the write.
    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output int waits);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!PREADY) begin
            checks++; errors++;
            $display("FAIL apb_write_timeout addr=%h: PREADY still %b after %0d cycles, need 1", addr, PREADY, waits);
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        data = PRDATA;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] w, input logic [31:0] d, input logic [31:0] ctrl,
                          input logic [31:0] exp_enc, input logic [31:0] exp_out, input string name);
        int waits;
        int n;
        logic [31:0] rd;
        logic [2:0] exp_mode;
        exp_mode = (w == 2'd0) ? 3'b100 : (w == 2'd1) ? 3'b010 : 3'b001;
        apb_write(A_WIDTH, {30'b0, w}, waits);
        apb_write(A_DATA_IN, d, waits);
        apb_write(A_CTRL, ctrl, waits);
        checks++;
        if ({Small, Medium, Large} !== exp_mode) begin
            errors++;
            $display("FAIL %s_mode: got SML=%b, need %b", name, {Small, Medium, Large}, exp_mode);
        end
        checks++;
        if (enc_data !== exp_enc) begin
            errors++;
            $display("FAIL %s_enc_data: got %h, need %h", name, enc_data, exp_enc);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!operation_done && n < 6);
        checks++;
        if (n !== 2 || operation_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: done seen after %0d cycles (done=%b), need 2", name, n, operation_done);
        end
        @(posedge clk); #1;
        checks++;
        if (operation_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: operation_done %b one cycle later, need 0", name, operation_done);
        end
        apb_read(A_DATA_OUT, rd);
        checks++;
        if (rd !== exp_out) begin
            errors++;
            $display("FAIL %s_data_out: got %h, need %h", name, rd, exp_out);
        end
        checks++;
        if ({Small, Medium, Large} !== exp_mode || enc_data !== exp_enc) begin
            errors++;
            $display("FAIL %s_hold: idle SML=%b enc=%h, need %b %h", name, {Small, Medium, Large}, enc_data, exp_mode, exp_enc);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        checks++;
        if (PREADY !== 1'b1 || operation_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_done: PREADY=%b done=%b, need 1 0", PREADY, operation_done);
        end
        checks++;
        if ({Small, Medium, Large} !== 3'b000 || enc_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: SML=%b enc=%h, need 000 0", {Small, Medium, Large}, enc_data);
        end
        apb_read(A_DATA_OUT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h, need 0", rd); end
        apb_read(A_DATA_IN, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_data_in: got %h, need 0", rd); end
    endtask

    task automatic test_small();
        run_op(2'd0, 32'h0000_0001, 32'h0, 32'h1000_0000, 32'h0000_001B, "small_1");
        run_op(2'd0, 32'h0000_000F, 32'h0, 32'hF000_0000, 32'h0000_00FF, "small_f");
    endtask

    task automatic test_medium();
        run_op(2'd1, 32'h0000_0000, 32'h0, 32'h0000_0000, 32'h0000_0000, "medium_0");
    endtask

    task automatic test_large();
        run_op(2'd2, 32'h03FF_FFFF, 32'h0, 32'hFFFF_FFC0, 32'hFFFF_FFDD, "large_w2");
        run_op(2'd3, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFC0, 32'hFFFF_FFDD, "large_w3");
    endtask

    task automatic test_noise();
        int waits;
        logic [31:0] rd;
        apb_write(A_NOISE, 32'hFFFF_FF01, waits);
        apb_read(A_NOISE, rd);
        checks++;
`ifdef ECC_CTRL_NOISE_EN
        if (rd !== 32'hFFFF_FF01) begin errors++; $display("FAIL noise_readback: got %h, need ffffff01", rd); end
        run_op(2'd0, 32'h0000_0001, 32'h2, 32'h1000_0000, 32'h0000_001A, "noise_on");
`else
        if (rd !== 32'h0) begin errors++; $display("FAIL noise_readback: got %h, need 0", rd); end
        run_op(2'd0, 32'h0000_0001, 32'h2, 32'h1000_0000, 32'h0000_001B, "noise_on");
`endif
        run_op(2'd0, 32'h0000_0001, 32'h0, 32'h1000_0000, 32'h0000_001B, "noise_off");
    endtask

    task automatic test_unmapped();
        int waits;
        logic [31:0] rd;
        apb_write(A_UNMAPPED, 32'h1234_5678, waits);
        apb_read(A_UNMAPPED, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, need 0", rd); end
        apb_write(A_DATA_OUT, 32'hCAFE_F00D, waits);
        apb_read(A_DATA_OUT, rd);
        checks++;
        if (rd !== 32'h0000_001B) begin errors++; $display("FAIL data_out_ro: got %h, need 0000001b", rd); end
        apb_read(A_WIDTH, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL width_readback: got %h, need 0", rd); end
    endtask

    task automatic test_busy_write();
        int waits;
        int d0;
        logic [31:0] rd;
        apb_write(A_WIDTH, 32'h0, waits);
        apb_write(A_DATA_IN, 32'h1, waits);
        d0 = done_cnt;
        apb_write(A_CTRL, 32'h0, waits);
        apb_write(A_DATA_IN, 32'hF, waits);
        checks++;
        if (waits !== 2) begin errors++; $display("FAIL busy_wait_states: got %0d, need 2", waits); end
        checks++;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL busy_done_count: got %0d pulses, need 1", done_cnt - d0); end
        apb_read(A_DATA_IN, rd);
        checks++;
        if (rd !== 32'hF) begin errors++; $display("FAIL busy_data_in: got %h, need f", rd); end
        apb_read(A_DATA_OUT, rd);
        checks++;
        if (rd !== 32'h1B) begin errors++; $display("FAIL busy_data_out: got %h, need 1b", rd); end
        run_op(2'd0, 32'hF, 32'h0, 32'hF000_0000, 32'h0000_00FF, "after_busy");
    endtask

    task automatic test_reset_mid_op();
        int waits;
        int d0;
        logic [31:0] rd;
        run_op(2'd0, 32'h1, 32'h0, 32'h1000_0000, 32'h0000_001B, "pre_reset");
        d0 = done_cnt;
        apb_write(A_CTRL, 32'h0, waits);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({Small, Medium, Large} !== 3'b000 || enc_data !== 32'h0 || PREADY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: SML=%b enc=%h ready=%b, need 000 0 1", {Small, Medium, Large}, enc_data, PREADY);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses, need 0", done_cnt - d0); end
        apb_read(A_DATA_OUT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midreset_data_out: got %h, need 0", rd); end
        run_op(2'd0, 32'h1, 32'h0, 32'h1000_0000, 32'h0000_001B, "post_reset");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_small();
        test_medium();
        test_large();
        test_noise();
        test_unmapped();
        test_busy_write();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
